// File: rtl/sdr_fifo_port_if.sv
// CPU-side register/handshake bundle of the serial data port.
// The master is the bus decoder; the slave is the port itself.
interface sdr_fifo_port_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) ();
    logic              mode;
    logic [DIV_W-1:0]  div;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              clr_ovr;
    logic              tx_full;
    logic              tx_empty;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_overrun;
    logic              busy;
    logic              irq;

    modport master (
        output mode, div, wr_en, wr_data, rd_en, clr_ovr,
        input  rd_data, tx_full, tx_empty, rx_full, rx_empty, rx_overrun, busy, irq
    );

    modport slave (
        input  mode, div, wr_en, wr_data, rd_en, clr_ovr,
        output rd_data, tx_full, tx_empty, rx_full, rx_empty, rx_overrun, busy, irq
    );
endinterface

// File: rtl/sdr_fifo_port.sv
// Serial data port with TX/RX FIFOs: master mode drives CNT from a divider,
// slave mode samples the synchronised cnt_in/sp_in pins.
//   state | meaning
//   IDLE  | shifter empty, cnt_out high
//   LOW   | cnt_out low, current MSB presented on sp_out
//   HIGH  | cnt_out high, bit consumed; next bit or next word follows
module sdr_fifo_port #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    sdr_fifo_port_if.slave   bus,
    input  logic             sp_in,
    output logic             sp_out,
    input  logic             cnt_in,
    output logic             cnt_out
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] BITS_C  = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] LAST_C  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  tx_wp, tx_rp;
    logic [CNT_W-1:0]  tx_cnt;
    logic              tx_full, tx_empty, tx_push, tx_pop, tx_done;

    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rx_wp, rx_rp;
    logic [CNT_W-1:0]  rx_cnt;
    logic              rx_full, rx_empty, rx_push, rx_pop, rx_ovr;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
    logic [DATA_W-1:0] tx_sh, tx_sh_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic              cnt_out_q, sp_out_q, busy_q, irq_q;

    logic [2:0]        cnt_sync;
    logic [1:0]        sp_sync;
    logic              cnt_rise;
    logic [DATA_W-1:0] rx_sh;
    logic [BIT_W-1:0]  rx_bits;
    logic              rx_done;

    assign tx_full  = (tx_cnt == DEPTH_C);
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = bus.wr_en && !tx_full;

    assign rx_full  = (rx_cnt == DEPTH_C);
    assign rx_empty = (rx_cnt == '0);
    assign rx_pop   = bus.rd_en && !rx_empty;
    // a pop in the same cycle frees the slot the incoming word needs
    assign rx_push  = rx_done && (!rx_full || rx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= bus.wr_data;
        if (rx_push) rx_mem[rx_wp] <= rx_sh;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            rx_ovr <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
            if (rx_done && !rx_push)  rx_ovr <= 1'b1;
            else if (bus.clr_ovr)     rx_ovr <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            tx_sh   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
            tx_sh   <= tx_sh_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        div_cnt_nxt = div_cnt;
        tx_sh_nxt   = tx_sh;
        bit_cnt_nxt = bit_cnt;
        tx_pop      = 1'b0;
        tx_done     = 1'b0;
        if (!bus.mode) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!tx_empty) begin
                        tx_pop      = 1'b1;
                        tx_sh_nxt   = tx_mem[tx_rp];
                        bit_cnt_nxt = BITS_C;
                        div_cnt_nxt = bus.div;
                        state_nxt   = LOW;
                    end
                end
                LOW: begin
                    if (div_cnt == '0) begin
                        state_nxt   = HIGH;
                        div_cnt_nxt = bus.div;
                        tx_sh_nxt   = {tx_sh[DATA_W-2:0], 1'b0};
                        bit_cnt_nxt = bit_cnt - 1'b1;
                    end else begin
                        div_cnt_nxt = div_cnt - 1'b1;
                    end
                end
                HIGH: begin
                    if (div_cnt != '0) begin
                        div_cnt_nxt = div_cnt - 1'b1;
                    end else if (bit_cnt != '0) begin
                        state_nxt   = LOW;
                        div_cnt_nxt = bus.div;
                    end else begin
                        tx_done = 1'b1;
                        if (!tx_empty) begin
                            tx_pop      = 1'b1;
                            tx_sh_nxt   = tx_mem[tx_rp];
                            bit_cnt_nxt = BITS_C;
                            div_cnt_nxt = bus.div;
                            state_nxt   = LOW;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // pins follow the state one clock later; mode gates them so an abort shows at once
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_out_q <= 1'b1;
            sp_out_q  <= 1'b1;
            busy_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            cnt_out_q <= !(bus.mode && state == LOW);
            if (bus.mode && state == LOW) sp_out_q <= tx_sh[DATA_W-1];
            busy_q    <= bus.mode && (state != IDLE);
            irq_q     <= tx_done || rx_done;
        end
    end

    // CNT idles high, so the synchronisers reset high to avoid a false edge
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_sync <= '1;
            sp_sync  <= '1;
        end else begin
            cnt_sync <= {cnt_sync[1:0], cnt_in};
            sp_sync  <= {sp_sync[0], sp_in};
        end
    end

    assign cnt_rise = cnt_sync[1] && !cnt_sync[2];

    always_ff @(posedge clk) begin
        if (reset || bus.mode) begin
            rx_sh   <= '0;
            rx_bits <= '0;
            rx_done <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (cnt_rise) begin
                rx_sh <= {rx_sh[DATA_W-2:0], sp_sync[1]};
                if (rx_bits == LAST_C) begin
                    rx_bits <= '0;
                    rx_done <= 1'b1;
                end else begin
                    rx_bits <= rx_bits + 1'b1;
                end
            end
        end
    end

    assign bus.rd_data    = rx_empty ? '0 : rx_mem[rx_rp];
    assign bus.tx_full    = tx_full;
    assign bus.tx_empty   = tx_empty;
    assign bus.rx_full    = rx_full;
    assign bus.rx_empty   = rx_empty;
    assign bus.rx_overrun = rx_ovr;
    assign bus.busy       = busy_q;
    assign bus.irq        = irq_q;
    assign cnt_out        = cnt_out_q;
    assign sp_out         = sp_out_q;
endmodule

// File: tb/tb_sdr_fifo_port.sv
// Self-checking bench for sdr_fifo_port: TX waveforms are predicted from the
// written words and divider, RX words are tracked in a depth-limited queue.
module tb_sdr_fifo_port;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic sp_in, cnt_in, sp_out, cnt_out;

    sdr_fifo_port_if #(.DATA_W(DW), .DIV_W(16)) bus ();

    sdr_fifo_port #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .sp_in   (sp_in),
        .sp_out  (sp_out),
        .cnt_in  (cnt_in),
        .cnt_out (cnt_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int irq_count = 0;

    logic [DW-1:0] mq[$];
    logic [2:0]    exp_q[$];
    logic          last_sp = 1'b1;
    logic [DW-1:0] rxq[$];

    always @(negedge clk) if (bus.irq === 1'b1) irq_count++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {cnt_out, sp_out, irq} per clock for the words in mq.
    function automatic void build_exp(input int dv, input int lead);
        exp_q.delete();
        for (int i = 0; i < lead; i++) exp_q.push_back({1'b1, last_sp, 1'b0});
        foreach (mq[w]) begin
            for (int b = DW - 1; b >= 0; b--) begin
                for (int c = 0; c <= dv; c++) exp_q.push_back({1'b0, mq[w][b], 1'b0});
                for (int c = 0; c <= dv; c++) exp_q.push_back({1'b1, mq[w][b], (b == 0 && c == dv)});
            end
        end
        if (mq.size() > 0) last_sp = mq[mq.size()-1][0];
    endfunction

    task automatic drive_rx_word(input logic [DW-1:0] w, input bit pop_at_end);
        for (int b = DW - 1; b >= 0; b--) begin
            cnt_in = 1'b0;
            sp_in  = w[b];
            repeat (4) step();
            cnt_in = 1'b1;
            for (int s = 0; s < 4; s++) begin
                if (pop_at_end && b == 0 && s == 3) bus.rd_en = 1'b1;
                step();
                bus.rd_en = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({cnt_out, sp_out, bus.tx_empty, bus.rx_empty, bus.tx_full, bus.rx_full,
             bus.irq, bus.busy, bus.rx_overrun} !== 9'b111100000)
            $display("FAIL reset_flags: got %b want 111100000",
                     {cnt_out, sp_out, bus.tx_empty, bus.rx_empty, bus.tx_full, bus.rx_full,
                      bus.irq, bus.busy, bus.rx_overrun});
        else n_pass++;
        n_checks++;
        if (bus.rd_data !== '0) $display("FAIL reset_rd_data: got %h want 00", bus.rd_data);
        else n_pass++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_word();
        bus.mode = 1'b1;
        bus.div  = 16'd0;
        step();
        mq = '{8'hA5};
        build_exp(0, 2);
        for (int k = 0; k < exp_q.size(); k++) begin
            bus.wr_en   = (k == 0);
            bus.wr_data = 8'hA5;
            step();
            n_checks++;
            if ({cnt_out, sp_out, bus.irq} !== exp_q[k])
                $display("FAIL single_stream clk %0d: got %b want %b", k, {cnt_out, sp_out, bus.irq}, exp_q[k]);
            else n_pass++;
        end
        bus.wr_en = 1'b0;
        step();
        n_checks++;
        if ({cnt_out, sp_out, bus.busy, bus.irq} !== {1'b1, last_sp, 2'b00})
            $display("FAIL single_idle: got %b want %b", {cnt_out, sp_out, bus.busy, bus.irq}, {1'b1, last_sp, 2'b00});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.div = 16'd2;
        mq = '{8'h3C, 8'hC3, 8'hFF};
        build_exp(2, 2);
        for (int k = 0; k < exp_q.size(); k++) begin
            bus.wr_en = (k < mq.size());
            if (k < mq.size()) bus.wr_data = mq[k];
            step();
            n_checks++;
            if ({cnt_out, sp_out, bus.irq} !== exp_q[k])
                $display("FAIL b2b_stream clk %0d: got %b want %b", k, {cnt_out, sp_out, bus.irq}, exp_q[k]);
            else n_pass++;
            if (k == 2 + 2 * 48) begin
                n_checks++;
                if (bus.tx_empty !== 1'b1) $display("FAIL b2b_tx_empty: got %b want 1", bus.tx_empty);
                else n_pass++;
            end
        end
        bus.wr_en = 1'b0;
        step();
        n_checks++;
        if ({cnt_out, bus.busy} !== 2'b10) $display("FAIL b2b_idle: got %b want 10", {cnt_out, bus.busy});
        else n_pass++;
    endtask

    task automatic test_random_tx();
        for (int it = 0; it < 4; it++) begin
            int nw, dv;
            nw = $urandom_range(1, 4);
            dv = $urandom_range(0, 3);
            bus.div = 16'(dv);
            mq.delete();
            for (int i = 0; i < nw; i++) mq.push_back(DW'($urandom));
            build_exp(dv, 2);
            for (int k = 0; k < exp_q.size(); k++) begin
                bus.wr_en = (k < nw);
                if (k < nw) bus.wr_data = mq[k];
                step();
                n_checks++;
                if ({cnt_out, sp_out, bus.irq} !== exp_q[k])
                    $display("FAIL rand_stream it %0d clk %0d: got %b want %b", it, k, {cnt_out, sp_out, bus.irq}, exp_q[k]);
                else n_pass++;
            end
            bus.wr_en = 1'b0;
            step();
        end
    endtask

    task automatic test_tx_full();
        logic [DW-1:0] w[5];
        bus.mode = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            w[i] = DW'($urandom);
            bus.wr_en   = 1'b1;
            bus.wr_data = w[i];
            step();
            n_checks++;
            if (bus.tx_full !== (i >= 3)) $display("FAIL txfull_after_write %0d: got %b want %b", i, bus.tx_full, (i >= 3));
            else n_pass++;
        end
        bus.wr_en = 1'b0;
        mq = '{w[0], w[1], w[2], w[3]};
        bus.div  = 16'd0;
        bus.mode = 1'b1;
        build_exp(0, 1);
        for (int k = 0; k < exp_q.size(); k++) begin
            step();
            n_checks++;
            if ({cnt_out, sp_out, bus.irq} !== exp_q[k])
                $display("FAIL txfull_stream clk %0d: got %b want %b", k, {cnt_out, sp_out, bus.irq}, exp_q[k]);
            else n_pass++;
        end
        repeat (4) step();
        n_checks++;
        if ({cnt_out, bus.busy, bus.tx_empty} !== 3'b101)
            $display("FAIL txfull_drained: got %b want 101", {cnt_out, bus.busy, bus.tx_empty});
        else n_pass++;
    endtask

    task automatic test_abort();
        int c0;
        bus.div = 16'd1;
        mq = '{8'h81};
        build_exp(1, 2);
        for (int k = 0; k < 14; k++) begin
            bus.wr_en   = (k < 2);
            bus.wr_data = (k == 0) ? 8'h81 : 8'h42;
            step();
            n_checks++;
            if ({cnt_out, sp_out, bus.irq} !== exp_q[k])
                $display("FAIL abort_prefix clk %0d: got %b want %b", k, {cnt_out, sp_out, bus.irq}, exp_q[k]);
            else n_pass++;
        end
        bus.wr_en = 1'b0;
        bus.mode  = 1'b0;
        c0 = irq_count;
        step();
        n_checks++;
        if ({cnt_out, bus.busy, bus.tx_empty} !== 3'b100)
            $display("FAIL abort_now: got %b want 100", {cnt_out, bus.busy, bus.tx_empty});
        else n_pass++;
        repeat (20) step();
        n_checks++;
        if ({irq_count - c0, 31'(cnt_out)} !== {32'd0, 31'd1})
            $display("FAIL abort_quiet: got irqs %0d cnt_out %b want 0 and 1", irq_count - c0, cnt_out);
        else n_pass++;
        last_sp = 1'b0;
        mq = '{8'h42};
        bus.mode = 1'b1;
        build_exp(1, 1);
        for (int k = 0; k < exp_q.size(); k++) begin
            step();
            n_checks++;
            if ({cnt_out, sp_out, bus.irq} !== exp_q[k])
                $display("FAIL abort_resume clk %0d: got %b want %b", k, {cnt_out, sp_out, bus.irq}, exp_q[k]);
            else n_pass++;
        end
        step();
        bus.mode = 1'b0;
        step();
    endtask

    task automatic test_rx_single();
        int c0;
        c0 = irq_count;
        drive_rx_word(8'h5A, 1'b0);
        for (int i = 0; i < 6 && bus.rx_empty; i++) step();
        n_checks++;
        if ({bus.rx_empty, bus.rd_data} !== {1'b0, 8'h5A})
            $display("FAIL rx_word: got empty=%b data=%h want empty=0 data=5a", bus.rx_empty, bus.rd_data);
        else n_pass++;
        repeat (2) step();
        n_checks++;
        if (irq_count - c0 !== 1) $display("FAIL rx_irq: got %0d pulses want 1", irq_count - c0);
        else n_pass++;
        n_checks++;
        if (cnt_out !== 1'b1) $display("FAIL rx_cnt_out: got %b want 1", cnt_out);
        else n_pass++;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        n_checks++;
        if (bus.rx_empty !== 1'b1) $display("FAIL rx_pop_empty: got %b want 1", bus.rx_empty);
        else n_pass++;
    endtask

    task automatic test_rx_overrun();
        logic [DW-1:0] w;
        logic          ovr_m;
        rxq.delete();
        ovr_m = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = DW'($urandom);
            drive_rx_word(w, 1'b0);
            if (rxq.size() < DEPTH) rxq.push_back(w);
            else ovr_m = 1'b1;
            n_checks++;
            if ({bus.rx_full, bus.rx_overrun, bus.rd_data} !== {rxq.size() == DEPTH, ovr_m, rxq[0]})
                $display("FAIL ovr_word %0d: got full=%b ovr=%b head=%h want full=%b ovr=%b head=%h",
                         i, bus.rx_full, bus.rx_overrun, bus.rd_data, rxq.size() == DEPTH, ovr_m, rxq[0]);
            else n_pass++;
        end
        bus.clr_ovr = 1'b1;
        step();
        bus.clr_ovr = 1'b0;
        n_checks++;
        if (bus.rx_overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", bus.rx_overrun);
        else n_pass++;
        w = DW'($urandom);
        drive_rx_word(w, 1'b1);
        void'(rxq.pop_front());
        rxq.push_back(w);
        n_checks++;
        if ({bus.rx_full, bus.rx_overrun, bus.rd_data} !== {1'b1, 1'b0, rxq[0]})
            $display("FAIL ovr_push_pop: got full=%b ovr=%b head=%h want full=1 ovr=0 head=%h",
                     bus.rx_full, bus.rx_overrun, bus.rd_data, rxq[0]);
        else n_pass++;
        while (rxq.size() > 0) begin
            n_checks++;
            if (bus.rd_data !== rxq[0]) $display("FAIL ovr_drain: got %h want %h", bus.rd_data, rxq[0]);
            else n_pass++;
            bus.rd_en = 1'b1;
            step();
            bus.rd_en = 1'b0;
            void'(rxq.pop_front());
        end
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        n_checks++;
        if ({bus.rx_empty, bus.rd_data} !== {1'b1, 8'h00})
            $display("FAIL ovr_empty_read: got empty=%b data=%h want empty=1 data=00", bus.rx_empty, bus.rd_data);
        else n_pass++;
    endtask

    initial begin
        reset       = 1'b1;
        bus.mode    = 1'b0;
        bus.div     = '0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.clr_ovr = 1'b0;
        sp_in       = 1'b1;
        cnt_in      = 1'b1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_random_tx();
        test_tx_full();
        test_abort();
        test_rx_single();
        test_rx_overrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sdr_fifo_port.md
Name: sdr_fifo_port

Overview:
- Parametrised successor to the SoC's CIA-style serial data port (sp_in/sp_out/cnt_in/cnt_out).
- Adds configurable word width, independent TX/RX FIFOs, a programmable CNT divider, per-word interrupt pulse and sticky RX overrun.
- Sits behind the CPU bus decoder; pins route to the SoC serial-port pads.

Parameters:
- DATA_W, 8, bits per serial word, shifted MSB first.
- FIFO_DEPTH, 4, entries per FIFO; power of 2, minimum 2.
- DIV_W, 16, width of the CNT half-period divider.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  1 = output/master (drive CNT), 0 = input/slave (sample cnt_in).
- div  input  DIV_W  CNT half-period is div+1 clocks.
- wr_en  input  1  push wr_data into TX FIFO.
- wr_data  input  DATA_W  TX word.
- rd_en  input  1  pop RX FIFO head.
- rd_data  output  DATA_W  RX FIFO head (first-word-fall-through).
- clr_ovr  input  1  clear rx_overrun.
- tx_full  output  1  TX FIFO full.
- tx_empty  output  1  TX FIFO empty.
- rx_full  output  1  RX FIFO full.
- rx_empty  output  1  RX FIFO empty.
- rx_overrun  output  1  sticky: RX word dropped.
- busy  output  1  shifter active (output mode).
- irq  output  1  one-clock pulse per completed word, either direction.
- sp_in  input  1  serial data in (asynchronous).
- sp_out  output  1  serial data out.
- cnt_in  input  1  serial clock in (asynchronous).
- cnt_out  output  1  serial clock out.

Behaviour:
- Reset values: cnt_out=1, sp_out=1, busy=0, irq=0, rx_overrun=0.
- Reset values: both FIFOs empty, so tx_empty=1, rx_empty=1, tx_full=0, rx_full=0; rd_data=0.
- Reset mid-transfer aborts the shift and flushes both FIFOs.
- FIFOs: occupancy counter is clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
- wr_en while tx_full is ignored. rd_en while rx_empty is ignored; pointers do not move.
- RX push and pop in the same cycle while rx_full: pop first, then push; no overrun.
- Output-mode FSM states: IDLE, LOW, HIGH.
  - IDLE -> LOW when TX FIFO is not empty: pop a word into the shifter, bit count = DATA_W.
  - First cnt_out fall occurs 2 clocks after wr_en is sampled into an empty TX FIFO with the shifter idle.
  - Entering LOW: cnt_out=0, sp_out=current MSB, divider loaded with div.
  - LOW -> HIGH when the divider reaches 0: cnt_out=1 and the shifter shifts left.
  - HIGH -> LOW on divider 0 while bits remain.
  - After the last bit's HIGH phase: irq pulses for 1 clock.
    - If the TX FIFO is not empty, the next word loads with no gap and the FSM goes to LOW the next clock.
    - Otherwise the FSM goes to IDLE.
  - Each bit takes 2*(div+1) clocks. busy=1 in LOW and HIGH.
  - sp_out holds the last bit when idle.
- Input mode:
  - cnt_in and sp_in each pass through a 2-flop synchroniser.
  - A rising edge of synchronised cnt_in shifts synchronised sp_in into the LSB.
  - After DATA_W edges, the word is pushed to the RX FIFO 1 clock after the final edge, with an irq pulse in the same cycle.
  - Push into a full FIFO drops the word and sets rx_overrun.
  - rx_overrun stays set until clr_ovr or reset. If clr_ovr and a new overrun occur in the same cycle, set wins.
  - cnt_out=1 in input mode.
- Mode change mid-word:
  - The shifter and bit counter abort; the FSM returns to IDLE and cnt_out=1.
  - FIFO contents are kept; the partial word is discarded with no irq.
- div is sampled at each divider reload, so a change takes effect on the next phase.

Test Plan:
- Reset: hold reset 3 clocks -> cnt_out=1, sp_out=1, tx_empty=1, rx_empty=1, irq=0. Then write 0xA5 with div=0 -> cnt_out low 2 clocks after wr_en, sp_out sequence 1,0,1,0,0,1,0,1, each bit 2 clocks, irq pulse at clock 16 of the word.
- Back-to-back: write 0x3C, 0xC3, 0xFF with div=2 -> 24 CNT cycles with no idle gap, 3 irq pulses 48 clocks apart, tx_empty=1 after the third load.
- TX full: 5 writes with FIFO_DEPTH=4 and the shifter held off (mode=0) -> tx_full=1 after the 4th write; 5th write is ignored; exactly 4 words emerge after mode=1.
- Input: drive cnt_in with period 8 clocks and sp_in MSB-first 0x5A -> rx_empty falls, rd_data=0x5A, irq pulse; rd_en -> rx_empty=1.
- Overrun: receive 5 words without reading -> rx_full after 4, rx_overrun=1 on the 5th, FIFO head still the first word. clr_ovr -> rx_overrun=0. Push and pop in the same cycle while full -> no overrun.
- Abort: switch mode 1->0 after 3 bits of 0x81 -> cnt_out=1 next clock, no irq, busy=0, remaining TX words still queued.
